// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle accumulator control unit.
package ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } ctrl_state_e;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SKP = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JZ  = 4'b1101;
  localparam logic [3:0] OP_STA = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Instruction class flags; is_add/is_skip/is_cond refine the main classes.
  typedef struct packed {
    logic is_mem_rd;
    logic is_mem_wr;
    logic is_branch;
    logic is_halt;
    logic is_illegal;
    logic is_add;
    logic is_skip;
    logic is_cond;
  } ctrl_class_t;

endpackage

// File: rtl/control_fsm_if.sv
// Handshake/strobe bundle between the control unit and the datapath/memory side.
interface control_fsm_if #(
  parameter int OPCODE_W = 4,
  parameter int RETIRE_W = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                acc_zero;
  logic                incpc;
  logic                ldacc;
  logic                ldir;
  logic                ldpc;
  logic                rd;
  logic                wr;
  logic                y;
  logic                alu_add;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  opcode, mem_ready, acc_zero,
    output incpc, ldacc, ldir, ldpc, rd, wr, y, alu_add, halted, illegal, retired
  );

  modport slave (
    output opcode, mem_ready, acc_zero,
    input  incpc, ldacc, ldir, ldpc, rd, wr, y, alu_add, halted, illegal, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; any set bit above [3:0] makes the opcode illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output ctrl_class_t         cls
);
  logic       upper_nz;
  logic [3:0] op_low;

  assign op_low = op[3:0];

  if (OPCODE_W > 4) begin : g_upper
    assign upper_nz = |op[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  always_comb begin
    cls = '0;
    if (upper_nz) begin
      cls.is_illegal = 1'b1;
    end else begin
      unique case (op_low)
        OP_NOP: ;
        OP_LDA: cls.is_mem_rd = 1'b1;
        OP_ADD: begin
          cls.is_mem_rd = 1'b1;
          cls.is_add    = 1'b1;
        end
        OP_SKP: cls.is_skip = 1'b1;
        OP_JMP: cls.is_branch = 1'b1;
        OP_JZ: begin
          cls.is_branch = 1'b1;
          cls.is_cond   = 1'b1;
        end
        OP_STA: cls.is_mem_wr = 1'b1;
        OP_HLT: cls.is_halt = 1'b1;
        default: cls.is_illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for the accumulator datapath with memory ready handshake.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they execute as NOP.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int RETIRE_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master bus
);
  ctrl_state_e         state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  ctrl_class_t cls;
  logic        trap;
  logic        exec_done;
  logic        incpc_s, ldacc_s, ldir_s, ldpc_s, rd_s, wr_s, y_s, alu_add_s, halted_s;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op  (op_q),
    .cls (cls)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = cls.is_illegal;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    exec_done = 1'b0;
    incpc_s   = 1'b0;
    ldacc_s   = 1'b0;
    ldir_s    = 1'b0;
    ldpc_s    = 1'b0;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    y_s       = 1'b0;
    alu_add_s = 1'b0;
    halted_s  = 1'b0;

    unique case (state_q)
      FETCH: begin
        rd_s = 1'b1;
        if (bus.mem_ready) begin
          ldir_s  = 1'b1;
          incpc_s = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        op_d    = bus.opcode;
        state_d = EXEC;
      end
      EXEC: begin
        exec_done = 1'b1;
        if (cls.is_mem_rd) begin
          rd_s      = 1'b1;
          alu_add_s = cls.is_add;
          ldacc_s   = bus.mem_ready;
          exec_done = bus.mem_ready;
        end else if (cls.is_mem_wr) begin
          wr_s      = 1'b1;
          y_s       = 1'b1;
          exec_done = bus.mem_ready;
        end else if (cls.is_skip) begin
          incpc_s = 1'b1;
        end else if (cls.is_branch) begin
          ldpc_s = cls.is_cond ? bus.acc_zero : 1'b1;
        end
        if (cls.is_illegal) begin
          illegal_d = 1'b1;
        end
        // Every EXEC exit retires, including HLT and trapped illegal opcodes.
        if (exec_done) begin
          retired_d = retired_q + 1'b1;
          state_d   = (cls.is_halt || trap) ? HALT : FETCH;
        end
      end
      HALT: begin
        halted_s = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Reset kills strobes in the same cycle so an in-flight access is abandoned at once.
  assign bus.incpc   = incpc_s   & ~rst;
  assign bus.ldacc   = ldacc_s   & ~rst;
  assign bus.ldir    = ldir_s    & ~rst;
  assign bus.ldpc    = ldpc_s    & ~rst;
  assign bus.rd      = rd_s      & ~rst;
  assign bus.wr      = wr_s      & ~rst;
  assign bus.y       = y_s       & ~rst;
  assign bus.alu_add = alu_add_s & ~rst;
  assign bus.halted  = halted_s  & ~rst;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_control_fsm.sv
// Randomized scoreboard bench for control_fsm; expectations built per instruction from the ISA rules.
module tb_control_fsm;
  localparam int OW = 5;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  control_fsm_if #(.OPCODE_W(OW), .RETIRE_W(RW)) dif ();
  control_fsm #(.OPCODE_W(OW), .RETIRE_W(RW)) dut (.clk(clk), .rst(rst), .bus(dif));

  control_fsm_if #(.OPCODE_W(4), .RETIRE_W(4)) wif ();
  control_fsm #(.OPCODE_W(4), .RETIRE_W(4)) u_wrap (.clk(clk), .rst(rst_w), .bus(wif));

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          y;
    logic          ldacc;
    logic          alu_add;
    logic          incpc;
    logic          ldir;
    logic          ldpc;
    logic          halted;
    logic          illegal;
    logic [RW-1:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;
  int   m_ret = 0;
  bit   m_ill = 1'b0;
  bit   wrap_done = 1'b0;

  function automatic logic [OW-1:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    return r[OW-1:0];
  endfunction

  function automatic logic rnd_bit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this cycle.
  task automatic cyc(input logic r, input logic mr, input logic [OW-1:0] opc,
                     input logic az, input exp_t e_in);
    exp_t e;
    e         = e_in;
    e.retired = m_ret[RW-1:0];
    e.illegal = m_ill;
    rst            = r;
    dif.mem_ready  = mr;
    dif.opcode     = opc;
    dif.acc_zero   = az;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) cyc(1'b1, rnd_bit(), rnd_op(), rnd_bit(), e);
    m_ret = 0;
    m_ill = 1'b0;
  endtask

  task automatic fetch(input int fw);
    exp_t e;
    e = '0;
    e.rd = 1'b1;
    for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, rnd_op(), rnd_bit(), e);
    e.ldir  = 1'b1;
    e.incpc = 1'b1;
    cyc(1'b0, 1'b1, rnd_op(), rnd_bit(), e);
  endtask

  task automatic decode(input logic [OW-1:0] op);
    exp_t e;
    e = '0;
    cyc(1'b0, rnd_bit(), op, rnd_bit(), e);
  endtask

  task automatic halt_cycles(input int n);
    exp_t e;
    e = '0;
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, rnd_bit(), rnd_op(), rnd_bit(), e);
  endtask

  // EXEC phase; returns whether the core enters HALT afterwards.
  task automatic exec(input logic [OW-1:0] op, input int ew, input logic az, output bit halts);
    exp_t e;
    e     = '0;
    halts = 1'b0;
    case (int'(op))
      1, 2: begin
        e.rd      = 1'b1;
        e.alu_add = (op == 5'd2);
        for (int i = 0; i < ew; i++) cyc(1'b0, 1'b0, rnd_op(), az, e);
        e.ldacc = 1'b1;
        cyc(1'b0, 1'b1, rnd_op(), az, e);
      end
      14: begin
        e.wr = 1'b1;
        e.y  = 1'b1;
        for (int i = 0; i < ew; i++) cyc(1'b0, 1'b0, rnd_op(), az, e);
        cyc(1'b0, 1'b1, rnd_op(), az, e);
      end
      11: begin
        e.incpc = 1'b1;
        cyc(1'b0, rnd_bit(), rnd_op(), az, e);
      end
      12: begin
        e.ldpc = 1'b1;
        cyc(1'b0, rnd_bit(), rnd_op(), az, e);
      end
      13: begin
        e.ldpc = az;
        cyc(1'b0, rnd_bit(), rnd_op(), az, e);
      end
      0: cyc(1'b0, rnd_bit(), rnd_op(), az, e);
      15: begin
        cyc(1'b0, rnd_bit(), rnd_op(), az, e);
        halts = 1'b1;
      end
      default: begin
        cyc(1'b0, rnd_bit(), rnd_op(), az, e);
        m_ill = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        halts = 1'b1;
`endif
      end
    endcase
    m_ret = m_ret + 1;
  endtask

  task automatic instr(input logic [OW-1:0] op, input int fw, input int ew, input logic az);
    bit h;
    fetch(fw);
    decode(op);
    exec(op, ew, az, h);
    if (h) begin
      halt_cycles(20);
      do_reset(1);
    end
  endtask

  // Monitor: one output vector per cycle, popped and compared away from the edge.
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dif.rd, dif.wr, dif.y, dif.ldacc, dif.alu_add, dif.incpc, dif.ldir,
           dif.ldpc, dif.halted, dif.illegal, dif.retired};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle%0d outputs(rd wr y ldacc alu_add incpc ldir ldpc halted illegal retired): got %b_%h required %b_%h",
                 cyc_no, a[RW+9:RW], a.retired, e[RW+9:RW], e.retired);
      end
      n_cmp++;
      if (dif.rd === 1'b1 && dif.wr === 1'b1) begin
        n_bad++;
        $display("FAIL cycle%0d rd_wr_exclusive: got rd=1 wr=1 required not both", cyc_no);
      end
      cyc_no++;
    end
  end

  task automatic check_wrap(input logic [3:0] want, input string name);
    n_cmp++;
    if (wif.retired !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, wif.retired, want);
    end
  endtask

  // RETIRE_W=4 instance running back-to-back NOPs to exercise the counter wrap.
  initial begin
    rst_w         = 1'b1;
    wif.mem_ready = 1'b1;
    wif.opcode    = 4'd0;
    wif.acc_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_w = 1'b0;
    repeat (45) @(posedge clk);
    #1 check_wrap(4'd15, "wrap_15_nops");
    repeat (3) @(posedge clk);
    #1 check_wrap(4'd0, "wrap_16_nops");
    repeat (3) @(posedge clk);
    #1 check_wrap(4'd1, "wrap_17_nops");
    wrap_done = 1'b1;
  end

  initial begin
    logic [OW-1:0] legal_ops [8];
    logic [OW-1:0] op;
    exp_t e;
    legal_ops = '{5'd0, 5'd1, 5'd2, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    rst           = 1'b1;
    dif.mem_ready = 1'b0;
    dif.opcode    = '0;
    dif.acc_zero  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Zero-wait NOP, LDA, STA.
    instr(5'd0, 0, 0, 1'b0);
    instr(5'd1, 0, 0, 1'b0);
    instr(5'd14, 0, 0, 1'b0);
    // Read stall of 4 cycles in EXEC, then ADD with a stall.
    instr(5'd1, 0, 4, 1'b0);
    instr(5'd2, 2, 3, 1'b1);
    // JZ taken and not taken, JMP, SKP.
    instr(5'd13, 0, 0, 1'b1);
    instr(5'd13, 0, 0, 1'b0);
    instr(5'd12, 1, 0, 1'b0);
    instr(5'd11, 0, 0, 1'b1);
    // Illegal 0101, then an upper-bit illegal form of LDA.
    instr(5'd5, 0, 0, 1'b0);
    instr(5'h11, 0, 0, 1'b0);
    instr(5'd0, 0, 0, 1'b0);

    // Reset during a stalled STA write.
    fetch(1);
    decode(5'd14);
    e = '0;
    e.wr = 1'b1;
    e.y  = 1'b1;
    cyc(1'b0, 1'b0, rnd_op(), 1'b0, e);
    cyc(1'b0, 1'b0, rnd_op(), 1'b0, e);
    do_reset(1);
    instr(5'd0, 0, 0, 1'b0);

    // HLT holds the core until reset.
    instr(5'd15, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) op = rnd_op();
      else op = legal_ops[$urandom_range(0, 7)];
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit());
    end

    for (int i = 0; i < 200 && !wrap_done; i++) @(posedge clk);
    if (!wrap_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_timeout: got not done required done");
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle sequencing control unit for the 32-bit accumulator datapath. It replaces single-cycle opcode decoding with a fetch/decode/execute state machine. The machine holds memory strobes across a ready handshake, counts retired instructions and detects illegal opcodes. It drives the same datapath strobes as before (incpc, ldacc, ldir, ldpc, rd, wr, y) and sits between the instruction register/accumulator and the memory interface.

## Interface
- OPCODE_W, 4: opcode width. Bits above [3:0] must be zero for a legal opcode.
- RETIRE_W, 16: width of the retired-instruction counter.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  opcode field from the instruction register; sampled in DECODE
- mem_ready  in  1  memory has completed the current rd/wr access this cycle
- acc_zero  in  1  accumulator == 0; used by JZ
- incpc  out  1  increment program counter
- ldacc  out  1  load accumulator from the memory/ALU path
- ldir  out  1  load instruction register
- ldpc  out  1  load program counter from operand
- rd  out  1  memory read request
- wr  out  1  memory write request
- y  out  1  select accumulator onto the memory write bus
- alu_add  out  1  ALU adds instead of passing the operand (qualifies ldacc)
- halted  out  1  core is in HALT
- illegal  out  1  sticky flag: an illegal opcode was decoded since reset
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: FETCH, DECODE, EXEC, HALT. Reset state is FETCH.
- **FETCH:** rd=1 until mem_ready. In the mem_ready cycle, ldir=1 and incpc=1, and the next state is DECODE.
- **DECODE:** one cycle with no strobes. Latch opcode into op_q and go to EXEC.
- **EXEC** actions per op_q:
  - 0000 NOP: no strobes.
  - 0001 LDA: rd=1 until mem_ready; ldacc=1 in the mem_ready cycle.
  - 0010 ADD: as LDA, with alu_add=1 while rd=1.
  - 1011 SKP: incpc=1 for one cycle.
  - 1100 JMP: ldpc=1 for one cycle.
  - 1101 JZ: ldpc=acc_zero for one cycle.
  - 1110 STA: y=1 and wr=1 until mem_ready.
  - 1111 HLT: go to HALT.
  - Any other value is illegal: set `illegal`, then handle it as defined under Configuration.
- EXEC returns to FETCH when its action completes: the mem_ready cycle for memory ops, otherwise the single EXEC cycle.
- **HALT:** halted=1, all strobes 0. Only rst leaves HALT.
- `retired` increments by 1 on every EXEC exit, including the HLT exit, and wraps modulo 2^RETIRE_W.
- Invariants: rd and wr are never both 1. ldacc is never 1 outside an LDA/ADD mem_ready cycle.

## Timing
- Strobes are decoded combinationally from state, op_q and mem_ready. state, op_q, illegal and retired are registered.
- Reset values: every strobe 0, halted 0, illegal 0, retired 0. All strobes are forced to 0 in any cycle where rst=1.
- Latency with mem_ready tied high is 3 cycles per instruction (FETCH, DECODE, EXEC). Each stalled cycle of mem_ready=0 adds one cycle in FETCH or in a memory EXEC.
- A request (rd or wr) stays asserted and stable until the cycle mem_ready=1. mem_ready sampled while no request is pending is ignored.
- rst asserted mid-access abandons the access. rd/wr drop in that same cycle, and the next cycle is FETCH with the counter at 0.
- The opcode input needs to be valid only during DECODE.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in EXEC goes to HALT. halted=1 from the next cycle, and `retired` still increments.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal opcode executes as NOP and returns to FETCH. `illegal` is set in both builds.

## Structure
- Package ctrl_pkg holds:
  - the state enum: FETCH, DECODE, EXEC, HALT
  - opcode localparams: OP_NOP, OP_LDA, OP_ADD, OP_SKP, OP_JMP, OP_JZ, OP_STA, OP_HLT
- One sub-module, ctrl_decode: combinational classifier that maps op_q to is_mem_rd, is_mem_wr, is_branch, is_halt and is_illegal, including the upper-bit check for OPCODE_W > 4.
- control_fsm contains the state register, handshake logic, flags and counter.

## Test plan
- **Zero-wait NOP, LDA, STA:**
  - Stimulus: mem_ready=1, opcodes 0000, 0001, 1110.
  - Response: 9 cycles total, retired=3. ldacc=1 in cycle 6, wr=y=1 in cycle 9, never rd and wr together.
- **Read stall:**
  - Stimulus: LDA with mem_ready low for 4 cycles in EXEC.
  - Response: rd held high for 5 cycles, ldacc=1 only in the 5th, retired increments once.
- **JZ both ways:**
  - Stimulus: JZ with acc_zero=1, then JZ with acc_zero=0.
  - Response: ldpc=1 in the first EXEC, ldpc=0 in the second. SKP gives incpc=1 in EXEC.
- **Illegal opcode 0101:**
  - Response: illegal=1. With CTRL_ILLEGAL_TRAP_EN, halted=1 the next cycle and remains so for 20 cycles; without it, fetch resumes and halted stays 0.
- **Reset mid-STA:**
  - Stimulus: rst during a stalled wr.
  - Response: wr=0 in the rst cycle; FETCH with rd=1 the cycle after rst drops; retired=0, illegal=0.
- **Counter wrap:**
  - Stimulus: RETIRE_W=4, 17 NOPs.
  - Response: retired=1.
